// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//
// Receive-side monitor for a multiplexed 4-digit seven-segment display.
// It samples the active-low anode select and the active-low segment bus and
// waits until a digit slot has held one pattern for STABLE_CYCLES samples. It
// then decodes the glyph back to a 4-bit digit and stores it in a shadow slot.
// When all four slots have been captured, the whole 16-bit value is published
// on digits_out, and frame_valid pulses for one cycle.
//
// Parameters:
//   STABLE_CYCLES   consecutive identical samples required for a capture (>= 2)
//   TIMEOUT_CYCLES  cycles without a completed frame before timeout rises
//
// Ports:
//   clk             system clock
//   reset           synchronous reset, active-low
//   anode_bits      digit select, active-low one-hot (bit3 thousands .. bit0 ones)
//   seven_segments  segments {a,b,c,d,e,f,g} on [6:0], active-low
//   digits_out      last complete frame, thousands in [15:12] .. ones in [3:0]
//   frame_valid     one-cycle pulse when digits_out updates
//   seg_err         one-cycle pulse: a stable pattern is not a legal glyph
//   anode_err       one-cycle pulse on entry to a multi-low anode select
//   timeout         level: no frame completed within TIMEOUT_CYCLES
//
// Build option:
//   SEVEN_SEG_CAPTURE_HEX_EN  when defined, the glyphs A, b, C, d, E and F
//                             decode to 4'hA..4'hF. Otherwise they are illegal.
// -----------------------------------------------------------------------------
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_bits,
  input  logic [6:0]  seven_segments,
  output logic [15:0] digits_out,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err,
  output logic        timeout
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

  // Returns {legal, digit}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
`ifdef SEVEN_SEG_CAPTURE_HEX_EN
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
`endif
      default:    r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] count_low(input logic [3:0] a);
    logic [2:0] z;
    z = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) z = z + 3'd1;
    end
    return z;
  endfunction

  // Position of the low bit. Only meaningful for a legal one-hot-low select.
  function automatic logic [1:0] slot_of(input logic [3:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // The counter saturates at STABLE_CYCLES, so a long hold can never wrap
  // and fake a second stable point.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [3:0]       anode_p0;
  logic [6:0]       seg_p0;
  logic [CNT_W-1:0] stab_cnt_p0;

  state_t           state_p1;
  logic [15:0]      shadow_p1;
  logic [3:0]       mask_p1;
  logic             was_bad_p1;
  logic [TO_W-1:0]  to_cnt;

  logic       pair_same;
  logic [2:0] low_cnt;
  logic       one_hot;
  logic       anode_bad;
  logic       changed;
  logic [4:0] glyph;
  logic [1:0] slot;
  logic [3:0] slot_bit;
  logic       capture;
  logic       cap_legal;
  logic       frame_vld_p1;
  logic       frame_done_now;

  always_comb begin
    pair_same      = ({anode_bits, seven_segments} == {anode_p0, seg_p0});
    low_cnt        = count_low(anode_p0);
    one_hot        = (low_cnt == 3'd1);
    anode_bad      = (low_cnt >= 3'd2);
    changed        = (stab_cnt_p0 == CNT_W'(1));
    glyph          = decode_glyph(seg_p0);
    slot           = slot_of(anode_p0);
    slot_bit       = 4'b0001 << slot;
    capture        = (state_p1 == SETTLE) && (stab_cnt_p0 == CNT_MAX);
    cap_legal      = capture && glyph[4];
    frame_vld_p1   = (mask_p1 == 4'hF);
    frame_done_now = cap_legal && ((mask_p1 | slot_bit) == 4'hF);
  end

  // ---- stage p0: input sample pair and stability count ----
  // ---- stage p1: window FSM, shadow slots, frame publish ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      anode_p0    <= 4'hF;
      seg_p0      <= 7'h7F;
      stab_cnt_p0 <= '0;
      state_p1    <= WAIT;
      shadow_p1   <= 16'h0000;
      mask_p1     <= 4'h0;
      was_bad_p1  <= 1'b0;
      digits_out  <= 16'h0000;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      anode_p0    <= anode_bits;
      seg_p0      <= seven_segments;
      stab_cnt_p0 <= pair_same ? sat_inc(stab_cnt_p0) : CNT_W'(1);

      // Only the transition into a multi-low select is reported.
      was_bad_p1  <= anode_bad;
      anode_err   <= anode_bad && !was_bad_p1;
      seg_err     <= capture && !glyph[4];

      frame_valid <= frame_vld_p1;
      if (frame_vld_p1) digits_out <= shadow_p1;

      if (cap_legal) shadow_p1[{slot, 2'b00} +: 4] <= glyph[3:0];

      if (frame_vld_p1)
        mask_p1 <= cap_legal ? slot_bit : 4'h0;
      else if (cap_legal)
        mask_p1 <= mask_p1 | slot_bit;

      case (state_p1)
        WAIT: begin
          if (one_hot) state_p1 <= SETTLE;
        end
        SETTLE: begin
          // A change reloads the counter, so re-settling under a new anode
          // simply waits for the count to climb again.
          if (capture)
            state_p1 <= HELD;
          else if (changed && !one_hot)
            state_p1 <= WAIT;
        end
        HELD: begin
          if (changed) state_p1 <= one_hot ? SETTLE : WAIT;
        end
        default: state_p1 <= WAIT;
      endcase
    end
  end

  // A completing capture suppresses a coincident expiry. The counter then
  // clears on the frame_valid edge that follows.
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (frame_vld_p1) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (!timeout && !frame_done_now) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_LAST) timeout <= 1'b1;
    end
  end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side monitor for the multiplexed 4-digit seven-segment interface driven by the stopwatch.
- Samples the active-low anode select and active-low segment bus, and waits for each digit slot to hold steady.
- Decodes each segment pattern back into a 4-bit digit and reassembles the full 16-bit display value.
- Used in benches and on-board self-check to confirm what the display actually shows.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is captured; minimum 2.
- TIMEOUT_CYCLES, 1000000: cycles without a completed frame before timeout asserts.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- anode_bits  input  4  digit select, active-low one-hot; bit3 = thousands, bit0 = ones.
- seven_segments  input  7  segments {a,b,c,d,e,f,g} on bits [6:0], active-low.
- digits_out  output  16  last complete frame: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- frame_valid  output  1  one-cycle pulse when digits_out updates.
- seg_err  output  1  one-cycle pulse: stable pattern is not a legal glyph.
- anode_err  output  1  one-cycle pulse: anode_bits has more than one bit low.
- timeout  output  1  level: no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Clocking and reset:
  - One clock, clk; reset is synchronous and active-low (port reset, asserted at 0).
  - Reset values: digits_out = 16'h0000; frame_valid, seg_err, anode_err, timeout = 0.
  - Reset also clears the shadow registers, the captured mask, the stability counter and the timeout counter, and sets state = WAIT.
  - Reset mid-frame discards any partial capture.
- Input sampling:
  - anode_bits and seven_segments are registered once into a sample pair.
  - The stability counter increments while the sample pair equals the previous sample pair.
  - Any difference reloads the counter to 1.
- State machine (per digit window):
  - WAIT: anode sample is all-high (blank) or illegal; nothing is captured.
    - All-high is legal idle and raises no error.
    - Two or more bits low pulses anode_err once on entry to that condition and stays in WAIT.
    - A legal one-hot sample moves to SETTLE.
  - SETTLE: counter reaches STABLE_CYCLES → decode the pattern.
    - Legal glyph: write the digit to its shadow slot, set the mask bit, go to HELD.
    - Illegal glyph: pulse seg_err, leave the mask unchanged, go to HELD.
    - Any change in the sample pair restarts SETTLE (new anode) or returns to WAIT (blank or illegal anode).
  - HELD: no re-capture while the pair is unchanged.
    - Segment change under the same anode → SETTLE; a later capture overwrites that slot.
    - Anode change → SETTLE or WAIT, as above.
- Decode table, active-low {a..g}:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Anything else is illegal.
- Frame completion:
  - On the capture edge that makes the mask 4'b1111, digits_out loads the shadow registers (including the digit just captured) on the next edge, with frame_valid high for that one cycle. The mask clears on that same edge.
  - Latency from the first stable cycle on the input pins to the capture edge is STABLE_CYCLES+1 clocks.
- Timeout:
  - The counter increments every cycle and clears on frame_valid.
  - At TIMEOUT_CYCLES, timeout goes to 1 and holds until the next frame_valid.
  - The counter saturates while timeout is high.
- Simultaneous events: capture of the fourth digit together with a timeout expiry → frame_valid wins; the timeout counter clears and timeout stays 0.

Optional Feature:
- Macro: SEVEN_SEG_CAPTURE_HEX_EN.
- Defined: also decode A = 0001000, b = 1100000, C = 0110001, d = 1000010, E = 0110000, F = 0111000 to 4'hA–4'hF.
- Undefined: these patterns are illegal and pulse seg_err.

Test Plan (STABLE_CYCLES=4):
- Reset low for 2 cycles → all outputs 0, digits_out = 16'h0000; reset released with inputs blank → no pulses for 100 cycles.
- Drive anodes 0111/1011/1101/1110 for 8 cycles each with glyphs 1, 2, 3, 4 → one frame_valid pulse, digits_out = 16'h1234; capture of the ones digit occurs 5 clocks after it appears.
- Glyph held for only 3 cycles per anode (less than 4) → no capture, no frame_valid; afterwards ones held for 8 cycles with value 1001111 → slot captured as 1.
- anode_bits = 0011 for 10 cycles → exactly one anode_err pulse, no capture. Segments 1111110 stable under anode 1110 → one seg_err pulse, mask bit 0 stays clear. Repeat with the macro defined: pattern 0001000 → digit A, no seg_err.
- TIMEOUT_CYCLES = 50, no stimulus → timeout = 1 at cycle 50 and stays 1. A full 16'h0000 frame then clears timeout on its frame_valid.
- Reset pulsed after three digits are captured, then only the ones digit is sent → no frame_valid until all four are recaptured.
